// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register enable/flush sequencing for the 5-stage core:
// load-use stalls, taken-branch flushes, multi-cycle word accesses and halt drain.
module pipeline_hazard_ctrl #(
    parameter int MEM_LATENCY  = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  if_id_rs_i,
    input  logic [4:0]  if_id_rt_i,
    input  logic        if_id_uses_rt_i,
    input  logic        id_ex_mem_to_reg_i,
    input  logic        id_ex_reg_write_i,
    input  logic [4:0]  id_ex_rt_i,
    input  logic        ex_branch_taken_i,
    input  logic        mem_is_mem_inst_i,
    input  logic        mem_is_word_i,
    input  logic        mem_halted_i,
    output logic        pc_en_o,
    output logic        if_id_en_o,
    output logic        id_ex_en_o,
    output logic        ex_mem_en_o,
    output logic        mem_wb_en_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        halted_o,
    output logic [15:0] stall_count_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_e;

    localparam bit       MEM_MULTI = (MEM_LATENCY > 1);
    localparam logic [3:0] CNT_LOAD = MEM_MULTI ? 4'(MEM_LATENCY - 2) : 4'd0;
    localparam logic [2:0] DCNT_LOAD = 3'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  dcnt_q, dcnt_d;
    logic [15:0] stall_q;
    logic        halted_q;
    logic        advance;
    logic        mem_trig;
    logic        load_use;

    assign mem_trig = MEM_MULTI && mem_is_mem_inst_i && mem_is_word_i;

    // $0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = id_ex_mem_to_reg_i && id_ex_reg_write_i && (id_ex_rt_i != 5'd0) &&
                      ((id_ex_rt_i == if_id_rs_i) ||
                       (if_id_uses_rt_i && (id_ex_rt_i == if_id_rt_i)));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dcnt_d        = dcnt_q;
        advance       = 1'b0;
        pc_en_o       = 1'b0;
        if_id_en_o    = 1'b0;
        id_ex_en_o    = 1'b0;
        ex_mem_en_o   = 1'b0;
        mem_wb_en_o   = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;

        if (reset_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            state_d       = RUN;
            cnt_d         = 4'd0;
            dcnt_d        = 3'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_trig) begin
                        cnt_d   = CNT_LOAD;
                        state_d = MEM_WAIT;
                    end else begin
                        advance = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        advance = 1'b1;
                        state_d = RUN;
                    end
                end
                DRAIN: begin
                    ex_mem_en_o = 1'b1;
                    mem_wb_en_o = 1'b1;
                    if (dcnt_q == 3'd0) state_d = HALTED;
                    else                dcnt_d  = dcnt_q - 3'd1;
                end
                default: ;
            endcase

            if (advance) begin
                if (mem_halted_i) begin
                    ex_mem_en_o   = 1'b1;
                    mem_wb_en_o   = 1'b1;
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    dcnt_d        = DCNT_LOAD;
                    state_d       = DRAIN;
                end else if (ex_branch_taken_i) begin
                    pc_en_o       = 1'b1;
                    if_id_en_o    = 1'b1;
                    id_ex_en_o    = 1'b1;
                    ex_mem_en_o   = 1'b1;
                    mem_wb_en_o   = 1'b1;
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end else if (load_use) begin
                    id_ex_en_o    = 1'b1;
                    id_ex_flush_o = 1'b1;
                    ex_mem_en_o   = 1'b1;
                    mem_wb_en_o   = 1'b1;
                end else begin
                    pc_en_o     = 1'b1;
                    if_id_en_o  = 1'b1;
                    id_ex_en_o  = 1'b1;
                    ex_mem_en_o = 1'b1;
                    mem_wb_en_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= RUN;
            cnt_q    <= 4'd0;
            dcnt_q   <= 3'd0;
            stall_q  <= 16'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dcnt_q   <= dcnt_d;
            halted_q <= (state_d == HALTED);
            if ((state_q == RUN || state_q == MEM_WAIT) && !pc_en_o && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign halted_o      = halted_q && !reset_i;
    assign stall_count_o = stall_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl: main instance (latency 4),
// a latency-1 instance sharing its inputs, and a latency-15 instance for counter saturation.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic       if_id_uses_rt, id_ex_mem_to_reg, id_ex_reg_write;
  logic       ex_branch_taken, mem_is_mem_inst, mem_is_word, mem_halted;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, halted;
  logic [15:0] stall_count;
  logic [1:0]  state;

  logic pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1, if_id_flush1, id_ex_flush1, halted1;
  logic [15:0] stall_count1;
  logic [1:0]  state1;

  logic sat_reset, sat_word;
  logic s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_iff, s_idf, s_halted;
  logic [15:0] sat_count;
  logic [1:0]  sat_state;

  pipeline_hazard_ctrl #(.MEM_LATENCY(4), .DRAIN_CYCLES(2)) u_dut (
    .clk_i(clk), .reset_i(reset),
    .if_id_rs_i(if_id_rs), .if_id_rt_i(if_id_rt), .if_id_uses_rt_i(if_id_uses_rt),
    .id_ex_mem_to_reg_i(id_ex_mem_to_reg), .id_ex_reg_write_i(id_ex_reg_write),
    .id_ex_rt_i(id_ex_rt), .ex_branch_taken_i(ex_branch_taken),
    .mem_is_mem_inst_i(mem_is_mem_inst), .mem_is_word_i(mem_is_word), .mem_halted_i(mem_halted),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en), .ex_mem_en_o(ex_mem_en),
    .mem_wb_en_o(mem_wb_en), .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
    .halted_o(halted), .stall_count_o(stall_count), .state_o(state)
  );

  pipeline_hazard_ctrl #(.MEM_LATENCY(1), .DRAIN_CYCLES(2)) u_ml1 (
    .clk_i(clk), .reset_i(reset),
    .if_id_rs_i(if_id_rs), .if_id_rt_i(if_id_rt), .if_id_uses_rt_i(if_id_uses_rt),
    .id_ex_mem_to_reg_i(id_ex_mem_to_reg), .id_ex_reg_write_i(id_ex_reg_write),
    .id_ex_rt_i(id_ex_rt), .ex_branch_taken_i(ex_branch_taken),
    .mem_is_mem_inst_i(mem_is_mem_inst), .mem_is_word_i(mem_is_word), .mem_halted_i(mem_halted),
    .pc_en_o(pc_en1), .if_id_en_o(if_id_en1), .id_ex_en_o(id_ex_en1), .ex_mem_en_o(ex_mem_en1),
    .mem_wb_en_o(mem_wb_en1), .if_id_flush_o(if_id_flush1), .id_ex_flush_o(id_ex_flush1),
    .halted_o(halted1), .stall_count_o(stall_count1), .state_o(state1)
  );

  pipeline_hazard_ctrl #(.MEM_LATENCY(15), .DRAIN_CYCLES(2)) u_sat (
    .clk_i(clk), .reset_i(sat_reset),
    .if_id_rs_i(5'd0), .if_id_rt_i(5'd0), .if_id_uses_rt_i(1'b0),
    .id_ex_mem_to_reg_i(1'b0), .id_ex_reg_write_i(1'b0),
    .id_ex_rt_i(5'd0), .ex_branch_taken_i(1'b0),
    .mem_is_mem_inst_i(sat_word), .mem_is_word_i(sat_word), .mem_halted_i(1'b0),
    .pc_en_o(s_pc), .if_id_en_o(s_ifid), .id_ex_en_o(s_idex), .ex_mem_en_o(s_exmem),
    .mem_wb_en_o(s_memwb), .if_id_flush_o(s_iff), .id_ex_flush_o(s_idf),
    .halted_o(s_halted), .stall_count_o(sat_count), .state_o(sat_state)
  );

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, halted}
  wire [7:0] ctl  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, halted};
  wire [7:0] ctl1 = {pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1, if_id_flush1, id_ex_flush1, halted1};

  localparam logic [7:0] C_RST  = 8'b00000_11_0;
  localparam logic [7:0] C_ALL  = 8'b11111_00_0;
  localparam logic [7:0] C_LU   = 8'b00111_01_0;
  localparam logic [7:0] C_BR   = 8'b11111_11_0;
  localparam logic [7:0] C_FRZ  = 8'b00000_00_0;
  localparam logic [7:0] C_HDET = 8'b00011_11_0;
  localparam logic [7:0] C_DRN  = 8'b00011_00_0;
  localparam logic [7:0] C_HLT  = 8'b00000_00_1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic m2r, input logic rw, input logic [4:0] xrt,
                        input logic br, input logic memi, input logic word, input logic hlt);
    if_id_rs = rs; if_id_rt = rt; if_id_uses_rt = uses_rt;
    id_ex_mem_to_reg = m2r; id_ex_reg_write = rw; id_ex_rt = xrt;
    ex_branch_taken = br; mem_is_mem_inst = memi; mem_is_word = word; mem_halted = hlt;
  endtask

  task automatic clear_in();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Checks this cycle's controls (and stall count unless exp_stall < 0), then moves to the next negedge.
  task automatic cyc(input string tag, input logic [7:0] exp_ctl, input int exp_stall);
    #1;
    check({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
    if (exp_stall >= 0) check({tag, "_stall"}, 32'(stall_count), exp_stall);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    sat_reset = 1'b1;
    sat_word  = 1'b0;
    clear_in();
    reset      = 1'b1;
    mem_halted = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc("reset1", C_RST, 0);
    cyc("reset2", C_RST, 0);
    reset = 1'b0;
    clear_in();
    cyc("post_reset", C_ALL, 0);

    set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs", C_LU, 0);
    clear_in();
    cyc("lu_after", C_ALL, 1);
    set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_r0", C_ALL, 1);
    set_in(5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rt", C_LU, 1);
    set_in(5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rt_unused", C_ALL, 2);
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("br_and_lu", C_BR, 2);
    clear_in();
    cyc("br_after", C_ALL, 2);

    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("byte_acc", C_ALL, 2);

    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1 check("ml1_word_ctl", 32'(ctl1), 32'(C_ALL));
    cyc("word_trig", C_FRZ, 2);
    cyc("word_w1", C_FRZ, 3);
    cyc("word_w2", C_FRZ, 4);
    cyc("word_rel", C_ALL, 5);
    clear_in();
    #1 check("ml1_stall", 32'(stall_count1), 32'd2);

    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("wbr_trig", C_FRZ, 5);
    cyc("wbr_w1", C_FRZ, 6);
    cyc("wbr_w2", C_FRZ, 7);
    cyc("wbr_rel", C_BR, 8);
    clear_in();
    cyc("wbr_after", C_ALL, 8);

    set_in(5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("wlu_trig", C_FRZ, 8);
    cyc("wlu_w1", C_FRZ, 9);
    cyc("wlu_w2", C_FRZ, 10);
    cyc("wlu_rel", C_LU, 11);
    clear_in();
    cyc("wlu_after", C_ALL, 12);

    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("halt_det", C_HDET, 12);
    clear_in();
    cyc("drain1", C_DRN, 13);
    cyc("drain2", C_DRN, 13);
    cyc("halted1", C_HLT, 13);
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc("halted_sticky", C_HLT, 13);
    clear_in();
    reset = 1'b1;
    cyc("reset_halted", C_RST, -1);
    reset = 1'b0;
    cyc("run_again", C_ALL, 0);

    sat_reset = 1'b0;
    sat_word  = 1'b1;
    repeat (15) @(negedge clk);
    #1 check("sat_first_round", 32'(sat_count), 32'd14);
    repeat (74985) @(negedge clk);
    #1 check("sat_70000", 32'(sat_count), 32'hFFFF);
    repeat (30) @(negedge clk);
    #1 check("sat_hold", 32'(sat_count), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
